// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch unit with an AR/R read port
// and a valid/ready instruction output; the next PC arrives only from the core.
module ifu_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
)(
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] araddr,
   output logic            arvalid,
   input  logic            arready,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rvalid,
   output logic            rready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   input  logic            pc_upd_valid,
   input  logic [XLEN-1:0] pc_upd,
   output logic            fetch_err,
   output logic [31:0]     fetch_cnt
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT_R,
      S_HOLD,
      S_WAIT_PC,
      S_ERR
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_inst_pc;
   logic [31:0]     r_fetch_cnt;
   logic            r_run;
   logic            w_aligned;
   logic            w_capture;
   logic            w_load_pc;

   // r_run keeps arvalid low on the reset edge itself; requests start one cycle after release
   assign w_aligned = (r_pc[1:0] == 2'b00);
   assign w_capture = (r_state == S_WAIT_R) && rvalid && (rresp == 2'b00);
   assign w_load_pc = pc_upd_valid &&
                      (((r_state == S_HOLD) && inst_ready) || (r_state == S_WAIT_PC));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ: begin
            if (r_run) begin
               if (!w_aligned)
                  w_state_nxt = S_ERR;
               else if (arready)
                  w_state_nxt = S_WAIT_R;
            end
         end
         S_WAIT_R: begin
            if (rvalid)
               w_state_nxt = (rresp == 2'b00) ? S_HOLD : S_ERR;
         end
         S_HOLD: begin
            if (inst_ready)
               w_state_nxt = pc_upd_valid ? S_REQ : S_WAIT_PC;
         end
         S_WAIT_PC: begin
            if (pc_upd_valid)
               w_state_nxt = S_REQ;
         end
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_inst      <= 32'd0;
         r_inst_pc   <= '0;
         r_fetch_cnt <= 32'd0;
         r_run       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
         if (w_capture) begin
            r_inst      <= rdata;
            r_inst_pc   <= r_pc;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (w_load_pc)
            r_pc <= pc_upd;
      end
   end

   assign araddr     = r_pc;
   assign arvalid    = (r_state == S_REQ) && r_run && w_aligned;
   assign rready     = (r_state == S_WAIT_R);
   assign inst_valid = (r_state == S_HOLD);
   assign fetch_err  = (r_state == S_ERR);
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized bench for ifu_fetch; expected PC, instruction and
// fetch count come from a transaction-level model held in plain variables.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h80000000;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        pc_upd_valid;
   logic [31:0] pc_upd;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   int          checks;
   int          errors;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic [31:0] exp_cnt;

   ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .araddr       (araddr),
      .arvalid      (arvalid),
      .arready      (arready),
      .rdata        (rdata),
      .rresp        (rresp),
      .rvalid       (rvalid),
      .rready       (rready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .pc_upd_valid (pc_upd_valid),
      .pc_upd       (pc_upd),
      .fetch_err    (fetch_err),
      .fetch_cnt    (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; pc_upd_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      exp_pc  = RESET_PC;
      exp_cnt = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake arvalid=%b rready=%b inst_valid=%b fetch_err=%b required all 0",
                  arvalid, rready, inst_valid, fetch_err);
      end
      checks++;
      if (inst !== 32'd0 || inst_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs inst=%h inst_pc=%h fetch_cnt=%0d required 0/0/0", inst, inst_pc, fetch_cnt);
      end
      rst = 1'b1;
      step();
      exp_pc  = RESET_PC;
      exp_cnt = 32'd0;
      checks++;
      if (arvalid !== 1'b1 || araddr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_release arvalid=%b araddr=%h required 1/%h", arvalid, araddr, RESET_PC);
      end
   endtask

   // one fetch from REQ to HOLD with given AR and R stall lengths
   task automatic fetch_one(input logic [31:0] data, input int ar_stall, input int r_stall);
      arready = 1'b0;
      for (int i = 0; i < ar_stall; i++) begin
         pc_upd_valid = 1'($urandom_range(0, 1));
         pc_upd       = $urandom;
         checks++;
         if (arvalid !== 1'b1 || araddr !== exp_pc || rready !== 1'b0) begin
            errors++;
            $display("FAIL ar_stall arvalid=%b araddr=%h rready=%b required 1/%h/0", arvalid, araddr, rready, exp_pc);
         end
         step();
      end
      pc_upd_valid = 1'b0;
      arready = 1'b1;
      checks++;
      if (arvalid !== 1'b1 || araddr !== exp_pc) begin
         errors++;
         $display("FAIL ar_req arvalid=%b araddr=%h required 1/%h", arvalid, araddr, exp_pc);
      end
      step();
      arready = 1'b0;
      for (int i = 0; i < r_stall; i++) begin
         pc_upd_valid = 1'($urandom_range(0, 1));
         pc_upd       = $urandom;
         checks++;
         if (rready !== 1'b1 || inst_valid !== 1'b0 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_wait rready=%b inst_valid=%b arvalid=%b required 1/0/0", rready, inst_valid, arvalid);
         end
         step();
      end
      pc_upd_valid = 1'b0;
      rvalid = 1'b1; rdata = data; rresp = 2'b00;
      checks++;
      if (rready !== 1'b1) begin
         errors++;
         $display("FAIL r_ready rready=%b required 1", rready);
      end
      step();
      rvalid = 1'b0; rdata = $urandom;
      exp_cnt  = exp_cnt + 32'd1;
      exp_inst = data;
      checks++;
      if (inst_valid !== 1'b1 || inst !== data || inst_pc !== exp_pc || fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL fetch_out valid=%b inst=%h pc=%h cnt=%0d required 1/%h/%h/%0d",
                  inst_valid, inst, inst_pc, fetch_cnt, data, exp_pc, exp_cnt);
      end
   endtask

   // consume the held instruction and supply the next PC, same-cycle or via WAIT_PC
   task automatic retire(input int hold_stall, input bit same, input int wpc_stall, input logic [31:0] npc);
      inst_ready = 1'b0;
      for (int i = 0; i < hold_stall; i++) begin
         pc_upd_valid = 1'($urandom_range(0, 1));
         pc_upd       = $urandom;
         checks++;
         if (inst_valid !== 1'b1 || inst !== exp_inst || inst_pc !== exp_pc || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL hold_stall valid=%b inst=%h pc=%h arvalid=%b required 1/%h/%h/0",
                     inst_valid, inst, inst_pc, arvalid, exp_inst, exp_pc);
         end
         step();
      end
      inst_ready = 1'b1; pc_upd_valid = same; pc_upd = npc;
      step();
      inst_ready = 1'b0; pc_upd_valid = 1'b0; pc_upd = $urandom;
      if (!same) begin
         for (int i = 0; i < wpc_stall; i++) begin
            checks++;
            if (inst_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
               errors++;
               $display("FAIL wait_pc inst_valid=%b arvalid=%b rready=%b required 0/0/0", inst_valid, arvalid, rready);
            end
            step();
         end
         pc_upd_valid = 1'b1; pc_upd = npc;
         step();
         pc_upd_valid = 1'b0; pc_upd = $urandom;
      end
      exp_pc = npc;
      checks++;
      if (inst_valid !== 1'b0 || arvalid !== (npc[1:0] == 2'b00) || araddr !== npc) begin
         errors++;
         $display("FAIL next_req inst_valid=%b arvalid=%b araddr=%h required 0/%b/%h",
                  inst_valid, arvalid, araddr, (npc[1:0] == 2'b00), npc);
      end
   endtask

   task automatic test_first_fetch();
      fetch_one(32'h00000413, 0, 0);
      checks++;
      if (fetch_cnt !== 32'd1 || inst_pc !== RESET_PC) begin
         errors++;
         $display("FAIL first_fetch cnt=%0d pc=%h required 1/%h", fetch_cnt, inst_pc, RESET_PC);
      end
   endtask

   task automatic test_hold_and_skip();
      retire(5, 1'b1, 0, 32'h80000010);
   endtask

   task automatic test_ar_stall();
      fetch_one($urandom, 3, 0);
   endtask

   task automatic test_wait_pc();
      retire(0, 1'b0, 3, 32'h80000020);
      fetch_one($urandom, 0, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] npc;
         npc = $urandom & 32'hFFFFFFFC;
         retire($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), npc);
         fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] cnt_before;
      cnt_before = exp_cnt;
      retire(1, 1'b1, 0, 32'h80000006);
      step();
      for (int i = 0; i < 4; i++) begin
         arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; pc_upd_valid = 1'b1; pc_upd = 32'h80000000;
         checks++;
         if (fetch_err !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 ||
             fetch_cnt !== cnt_before) begin
            errors++;
            $display("FAIL misaligned err=%b arvalid=%b rready=%b inst_valid=%b cnt=%0d required 1/0/0/0/%0d",
                     fetch_err, arvalid, rready, inst_valid, fetch_cnt, cnt_before);
         end
         step();
      end
      arready = 1'b0; rvalid = 1'b0; pc_upd_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      arready = 1'b1;
      step();
      arready = 1'b0;
      checks++;
      if (rready !== 1'b1) begin
         errors++;
         $display("FAIL mid_wait_r rready=%b required 1", rready);
      end
      rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
      step();
      checks++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 ||
          inst !== 32'd0 || inst_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset arvalid=%b rready=%b iv=%b err=%b inst=%h pc=%h cnt=%0d required all 0",
                  arvalid, rready, inst_valid, fetch_err, inst, inst_pc, fetch_cnt);
      end
      rst = 1'b1;
      step();
      rvalid = 1'b0;
      exp_pc = RESET_PC; exp_cnt = 32'd0;
      checks++;
      if (arvalid !== 1'b1 || araddr !== RESET_PC || inst_valid !== 1'b0 || inst !== 32'd0) begin
         errors++;
         $display("FAIL mid_restart arvalid=%b araddr=%h iv=%b inst=%h required 1/%h/0/0",
                  arvalid, araddr, inst_valid, inst, RESET_PC);
      end
      fetch_one($urandom, 1, 1);
   endtask

   task automatic test_rresp_err();
      do_reset();
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1; rresp = 2'b10; rdata = 32'h12345678;
      step();
      for (int i = 0; i < 4; i++) begin
         arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; inst_ready = 1'b1;
         checks++;
         if (fetch_err !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 ||
             fetch_cnt !== 32'd0 || inst !== 32'd0) begin
            errors++;
            $display("FAIL rresp_err err=%b arvalid=%b rready=%b iv=%b cnt=%0d inst=%h required 1/0/0/0/0/0",
                     fetch_err, arvalid, rready, inst_valid, fetch_cnt, inst);
         end
         step();
      end
      arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0;
      do_reset();
      checks++;
      if (fetch_err !== 1'b0 || arvalid !== 1'b1 || araddr !== RESET_PC) begin
         errors++;
         $display("FAIL err_recover err=%b arvalid=%b araddr=%h required 0/1/%h", fetch_err, arvalid, araddr, RESET_PC);
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rvalid = 1'b0;
      inst_ready = 1'b0; pc_upd_valid = 1'b0; pc_upd = 32'd0;
      checks = 0; errors = 0;
      exp_pc = RESET_PC; exp_inst = 32'd0; exp_cnt = 32'd0;
      test_reset();
      test_first_fetch();
      test_hold_and_skip();
      test_ar_stall();
      test_wait_pc();
      test_random();
      test_misaligned();
      test_reset_mid();
      test_rresp_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
